// File: rtl/tcdm_burst_master_if.sv
// TCDM request/response bus between a burst initiator and the interconnect.
//   req/add/wen/wdata/be : request channel driven by the master (wen=0 is a write)
//   gnt                  : request accepted by the interconnect
//   r_valid/r_rdata      : one response per granted request, one cycle after grant
interface tcdm_burst_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;
    logic                  gnt;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;

    modport master (
        output req, add, wen, wdata, be,
        input  gnt, r_valid, r_rdata
    );

    modport slave (
        input  req, add, wen, wdata, be,
        output gnt, r_valid, r_rdata
    );
endinterface

// File: rtl/tcdm_burst_master.sv
// Burst initiator: turns one command (word-aligned base, word count, direction)
// into consecutive 32-bit TCDM word requests. Write data arrives on a
// valid/ready stream, read data leaves through a small FIFO on a valid/ready
// stream. DATA_WIDTH must be 32; MAX_OUTSTANDING must be >= 1.
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o        : command handshake (addr, len, we)
//   wdata_valid_i/wdata_ready_o    : write data stream
//   rdata_valid_o/rdata_ready_i    : read data stream
//   tcdm                           : TCDM master port
//   busy_o                         : burst in progress
//   done_o                         : one-cycle pulse when a burst completes
//
// state | meaning
// IDLE  | accepting commands
// RUN   | issuing word requests, words still remaining
// DRAIN | all requests granted, waiting for responses / read FIFO to empty
module tcdm_burst_master #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  cmd_we_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    tcdm_burst_master_if.master   tcdm,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W:0]      MAX_CNT   = MAX_OUTSTANDING[CNT_W:0];
    localparam logic [CNT_W-1:0]    CNT_ONE   = 1;
    localparam logic [PTR_W-1:0]    PTR_ONE   = 1;
    localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = 4;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

    logic                  run;
    logic [CNT_W:0]        in_use;
    logic                  credit;
    logic                  req_issue;
    logic                  grant;
    logic                  resp;
    logic                  push;
    logic                  pop;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cmd_addr_i[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_ONE;
    endfunction

    // Reads also count words parked in the FIFO: responses cannot be stalled,
    // so every granted read must already own a FIFO slot.
    assign run       = (state_q == RUN);
    assign in_use    = {1'b0, outstanding_q} + (we_q ? '0 : {1'b0, fifo_cnt_q});
    assign credit    = (in_use < MAX_CNT);
    assign req_issue = run && (remaining_q != '0) && credit && (!we_q || wdata_valid_i);
    assign grant     = req_issue && tcdm.gnt;
    assign resp      = tcdm.r_valid && (outstanding_q != '0);
    assign push      = resp && !we_q;
    assign pop       = rdata_valid_o && rdata_ready_i;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({grant, resp})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        we_d        = we_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d      = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    remaining_d = cmd_len_i;
                    we_d        = cmd_we_i;
                    if (cmd_len_i != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (grant) begin
                    addr_d      = addr_q + ADDR_STEP;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Look at next-cycle counts so done lands the cycle right after
                // the final retire / pop.
                if ((outstanding_d == '0) && (we_q || (fifo_cnt_d == '0))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            we_q          <= 1'b0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            we_q          <= we_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            fifo_cnt_q    <= fifo_cnt_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr_q] <= tcdm.r_rdata;
        end
    end

    // Request fields are forced to zero outside RUN so the port is quiet in reset/idle.
    assign tcdm.req      = req_issue;
    assign tcdm.add      = run ? addr_q : '0;
    assign tcdm.wen      = run && !we_q;
    assign tcdm.be       = run ? 4'hF : 4'h0;
    assign tcdm.wdata    = (run && we_q) ? wdata_i : '0;

    assign cmd_ready_o   = (state_q == IDLE);
    assign wdata_ready_o = grant && we_q;
    assign rdata_valid_o = (fifo_cnt_q != '0);
    assign rdata_o       = rdata_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
endmodule

// File: tb/tb_tcdm_burst_master.sv
// Testbench for tcdm_burst_master: directed bursts against a TCDM slave model
// that responds one cycle after each grant, with a per-cycle checker built on
// word queues and credit counts.
module tb_tcdm_burst_master;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LW   = 16;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_we;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid;
    logic          rdata_ready;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          done;

    tcdm_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    tcdm_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .cmd_we_i     (cmd_we),
        .wdata_valid_i(wdata_valid),
        .wdata_ready_o(wdata_ready),
        .wdata_i      (wdata),
        .rdata_valid_o(rdata_valid),
        .rdata_ready_i(rdata_ready),
        .rdata_o      (rdata),
        .tcdm         (bus),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    logic [31:0] exp_add_q[$];
    logic [31:0] exp_wd_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] wq[$];
    bit  m_we       = 1'b0;
    bit  active     = 1'b0;
    int  accept_cyc = 0;
    int  done_due   = -10;
    int  out_m      = 0;
    int  fifo_m     = 0;
    bit  force_rv   = 1'b0;
    bit  chk_en     = 1'b0;

    // per-test observations
    int          n_gnt, first_gnt_cyc, last_gnt_cyc, n_pop, last_pop_cyc, n_done, last_done_cyc;
    logic [31:0] first_gnt_addr, last_gnt_addr;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic clr_stats();
        n_gnt = 0; first_gnt_cyc = -1; last_gnt_cyc = -1;
        n_pop = 0; last_pop_cyc = -1; n_done = 0; last_done_cyc = -1;
        first_gnt_addr = 32'hFFFF_FFFF; last_gnt_addr = 32'hFFFF_FFFF;
    endtask

    // TCDM slave and write-stream source
    logic        g_prev;
    logic [31:0] ga_prev;
    initial begin
        bus.r_valid = 1'b0;
        bus.r_rdata = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        forever begin
            @(negedge clk);
            g_prev  = bus.req & bus.gnt;
            ga_prev = bus.add;
            if (wdata_ready && wq.size() > 0) void'(wq.pop_front());
            @(posedge clk);
            #1;
            bus.r_valid = g_prev | force_rv;
            bus.r_rdata = g_prev ? rd_word(ga_prev) : 32'hDEAD_DEAD;
            wdata_valid = (wq.size() > 0);
            wdata       = (wq.size() > 0) ? wq[0] : 32'h0;
        end
    end

    // per-cycle compare against the queue/credit model
    always @(negedge clk) begin
        bit running, credit, req_e, gnt_now;
        if (chk_en) begin
            running = active && (cyc > accept_cyc);
            credit  = m_we ? (out_m < MAXO) : (out_m + fifo_m < MAXO);
            req_e   = running && (exp_add_q.size() > 0) && credit && (!m_we || wdata_valid);
            chk("busy", busy, running);
            chk("cmd_ready", cmd_ready, !running);
            chk("req", bus.req, req_e);
            chk("wdata_ready", wdata_ready, req_e && bus.gnt && m_we);
            chk("rdata_valid", rdata_valid, fifo_m > 0);
            chk("done", done, cyc == done_due);

            gnt_now = bus.req && bus.gnt;
            if (gnt_now) begin
                if (exp_add_q.size() == 0) begin
                    chk("grant_unexpected", 1, 0);
                end else begin
                    logic [31:0] ea;
                    ea = exp_add_q.pop_front();
                    chk("req_add", bus.add, ea);
                    chk("req_wen", bus.wen, !m_we);
                    chk("req_be", bus.be, 4'hF);
                    if (m_we) chk("req_wdata", bus.wdata, exp_wd_q.pop_front());
                    if (n_gnt == 0) begin
                        first_gnt_cyc  = cyc;
                        first_gnt_addr = bus.add;
                    end
                    last_gnt_cyc  = cyc;
                    last_gnt_addr = bus.add;
                    n_gnt++;
                end
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_rd_q.size() == 0) chk("pop_unexpected", 1, 0);
                else chk("rdata", rdata, exp_rd_q.pop_front());
                n_pop++;
                last_pop_cyc = cyc;
                if (fifo_m > 0) fifo_m--;
            end
            if (bus.r_valid && out_m > 0) begin
                out_m--;
                if (!m_we) fifo_m++;
            end
            if (gnt_now) out_m++;
            if (running && exp_add_q.size() == 0 && out_m == 0 && fifo_m == 0) begin
                done_due = cyc + 1;
                active   = 1'b0;
            end
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input int len, input bit we, input logic [31:0] wbase);
        logic [31:0] ad;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = LW'(len);
        cmd_we     = we;
        m_we       = we;
        accept_cyc = cyc;
        for (int i = 0; i < len; i++) begin
            ad = {a[31:2], 2'b00} + 32'(4 * i);
            exp_add_q.push_back(ad);
            if (we) begin
                exp_wd_q.push_back(wbase + 32'(i));
                wq.push_back(wbase + 32'(i));
            end else begin
                exp_rd_q.push_back(rd_word(ad));
            end
        end
        if (len == 0) done_due = cyc + 1;
        else active = 1'b1;
        @(negedge clk);
        chk("cmd_ready_at_accept", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (n_done == 0) chk("wait_done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input int n, input int budget);
        int k = 0;
        while (n_gnt < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (n_gnt < n) chk("wait_gnt_timeout", n_gnt, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_req"}, bus.req, 0);
        chk({tag, "_add"}, bus.add, 0);
        chk({tag, "_wen"}, bus.wen, 0);
        chk({tag, "_wdata"}, bus.wdata, 0);
        chk({tag, "_be"}, bus.be, 0);
        chk({tag, "_wdata_ready"}, wdata_ready, 0);
        chk({tag, "_rdata_valid"}, rdata_valid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int t0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_we = 1'b0;
        rdata_ready = 1'b1; bus.gnt = 1'b0;
        clr_stats();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        bus.gnt = 1'b1;
        chk_en = 1'b1;

        // write burst at full throughput
        clr_stats();
        send_cmd(32'h1C00_0010, 4, 1'b1, 32'hA0);
        t0 = accept_cyc;
        wait_done(20);
        chk("wr_ngnt", n_gnt, 4);
        chk("wr_first_gnt_cyc", first_gnt_cyc, t0 + 1);
        chk("wr_last_gnt_cyc", last_gnt_cyc, t0 + 4);
        chk("wr_first_addr", first_gnt_addr, 32'h1C00_0010);
        chk("wr_last_addr", last_gnt_addr, 32'h1C00_001C);
        chk("wr_ndone", n_done, 1);
        chk("wr_done_cyc", last_done_cyc, t0 + 6);

        // read burst with output backpressure
        rdata_ready = 1'b0;
        clr_stats();
        send_cmd(32'h1C00_0100, 3, 1'b0, 32'h0);
        repeat (10) @(posedge clk);
        #2;
        chk("rd_bp_ngnt", n_gnt, 2);
        chk("rd_bp_req_low", bus.req, 0);
        rdata_ready = 1'b1;
        wait_done(30);
        chk("rd_bp_npop", n_pop, 3);
        chk("rd_bp_ndone", n_done, 1);
        chk("rd_bp_done_cyc", last_done_cyc, last_pop_cyc + 1);

        // grant stall in the middle of a write burst
        clr_stats();
        send_cmd(32'h1C00_0200, 4, 1'b1, 32'hB0);
        wait_gnt(2, 20);
        bus.gnt = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req", bus.req, 1);
            chk("stall_add", bus.add, 32'h1C00_0208);
            chk("stall_wdata", bus.wdata, 32'hB2);
            chk("stall_wready", wdata_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.gnt = 1'b1;
        wait_done(20);
        chk("stall_ngnt", n_gnt, 4);

        // zero-length command
        clr_stats();
        send_cmd(32'h1C00_0400, 0, 1'b0, 32'h0);
        t0 = accept_cyc;
        repeat (4) @(posedge clk);
        #2;
        chk("len0_ngnt", n_gnt, 0);
        chk("len0_ndone", n_done, 1);
        chk("len0_done_cyc", last_done_cyc, t0 + 1);

        // address wrap at the top of the address space
        clr_stats();
        send_cmd(32'hFFFF_FFFC, 2, 1'b0, 32'h0);
        wait_done(20);
        chk("wrap_first_addr", first_gnt_addr, 32'hFFFF_FFFC);
        chk("wrap_second_addr", last_gnt_addr, 32'h0000_0000);
        chk("wrap_npop", n_pop, 2);

        // unaligned base is truncated to a word boundary
        clr_stats();
        send_cmd(32'h1C00_0013, 1, 1'b1, 32'hC0);
        wait_done(20);
        chk("align_addr", first_gnt_addr, 32'h1C00_0010);
        chk("align_ngnt", n_gnt, 1);

        // reset with two reads outstanding, then spurious responses
        rdata_ready = 1'b0;
        clr_stats();
        send_cmd(32'h1C00_0500, 4, 1'b0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        active = 1'b0; out_m = 0; fifo_m = 0; done_due = -10;
        exp_add_q.delete(); exp_wd_q.delete(); exp_rd_q.delete(); wq.delete();
        check_reset_outputs("midrst");
        force_rv = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_rvalid", rdata_valid, 0);
        end
        @(posedge clk);
        #1;
        force_rv = 1'b0;
        rdata_ready = 1'b1;
        clr_stats();
        send_cmd(32'h1C00_0600, 2, 1'b0, 32'h0);
        wait_done(20);
        chk("post_rst_ngnt", n_gnt, 2);
        chk("post_rst_npop", n_pop, 2);
        chk("post_rst_ndone", n_done, 1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
